// File: rtl/fnd_scan_if.sv
// Signal bundle between a BCD producer and the FND scan controller.
// The controller takes the slave side; the producer or bench takes the master side.
interface fnd_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    en;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic                    load;
  logic [6:0]              fnd_seg;
  logic [NUM_DIGITS-1:0]   fnd_com;
  logic                    frame_done;

  modport master (
    output en, digits_in, load,
    input  fnd_seg, fnd_com, frame_done
  );

  modport slave (
    input  en, digits_in, load,
    output fnd_seg, fnd_com, frame_done
  );
endinterface

// File: rtl/fnd_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode 7-segment digits.
// It has a double-buffered frame, a guard gap per digit, and registered active-low outputs.
//
// state | meaning
// IDLE  | scanning disabled, outputs blank, index/counter held at 0
// SHOW  | current digit driven for DIGIT_CYC-GUARD_CYC cycles
// GUARD | all digits blanked for GUARD_CYC cycles before advancing
module fnd_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_CYC  = 50000,
  parameter int GUARD_CYC  = 500
) (
  input  logic        clk,
  input  logic        rst,
  fnd_scan_if.slave   bus
);

  localparam int CNT_W = $clog2(DIGIT_CYC);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(DIGIT_CYC - GUARD_CYC - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(DIGIT_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, SHOW, GUARD} state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [IDX_W-1:0]        idx, idx_nxt;
  logic                    wrap;
  logic [4*NUM_DIGITS-1:0] pending, active;
  logic                    pending_valid;
  logic [6:0]              seg_q, seg_nxt;
  logic [NUM_DIGITS-1:0]   com_q, com_nxt;
  logic                    frame_done_q;
  logic [3:0]              cur_bcd;

  function automatic logic [6:0] seg_map(input logic [3:0] bcd);
    case (bcd)
      4'd0:    seg_map = 7'b100_0000;
      4'd1:    seg_map = 7'b111_1001;
      4'd2:    seg_map = 7'b010_0100;
      4'd3:    seg_map = 7'b011_0000;
      4'd4:    seg_map = 7'b001_1001;
      4'd5:    seg_map = 7'b001_0010;
      4'd6:    seg_map = 7'b000_0010;
      4'd7:    seg_map = 7'b101_1000;
      4'd8:    seg_map = 7'b000_0000;
      4'd9:    seg_map = 7'b001_0000;
      default: seg_map = 7'b100_0000;
    endcase
  endfunction

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    wrap      = 1'b0;
    if (!bus.en) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      idx_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = SHOW;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end
        SHOW: begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == SHOW_LAST) state_nxt = GUARD;
        end
        GUARD: begin
          if (cnt == SLOT_LAST) begin
            cnt_nxt   = '0;
            state_nxt = SHOW;
            if (idx == IDX_LAST) begin
              idx_nxt = '0;
              wrap    = 1'b1;
            end else begin
              idx_nxt = idx + 1'b1;
            end
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output decode works from the current state, so pins lag the FSM by one cycle.
  always_comb begin
    com_nxt = '1;
    seg_nxt = 7'h7F;
    cur_bcd = active[{idx, 2'b00} +: 4];
    if (state == SHOW) begin
      com_nxt[idx] = 1'b0;
      seg_nxt      = seg_map(cur_bcd);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      pending      <= '0;
      active       <= '0;
      pending_valid <= 1'b0;
      seg_q        <= 7'h7F;
      com_q        <= '1;
      frame_done_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      idx          <= idx_nxt;
      seg_q        <= seg_nxt;
      com_q        <= com_nxt;
      frame_done_q <= wrap;
      // A load coinciding with the wrap copies the old pending value and keeps the new one pending.
      if (wrap && pending_valid) active <= pending;
      if (bus.load) begin
        pending       <= bus.digits_in;
        pending_valid <= 1'b1;
      end else if (wrap) begin
        pending_valid <= 1'b0;
      end
    end
  end

  assign bus.fnd_seg    = seg_q;
  assign bus.fnd_com    = com_q;
  assign bus.frame_done = frame_done_q;

endmodule
